e_stream_admit: RTL and testbench

- Streaming admission controller for unary/thermometer-coded vectors.
- Accepts one W-bit vector per cycle on a valid/ready input channel and classifies it as standard unary, complement unary, or invalid.
- Forwards admitted vectors as a decoded length plus a complement flag on a registered valid/ready output channel; drops invalid vectors.
- Keeps saturating accept/reject counters and a sticky error flag for status readout. Sits between a thermometer-coded producer and downstream length consumers.

---
 rtl/e_stream_admit.sv | 139 +++++++++++++
 tb/tb_e_stream_admit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/e_stream_admit.sv
// Streaming admission controller for thermometer-coded vectors: classifies each
// beat as standard/complement unary, forwards its length, drops and counts the rest.
module e_stream_admit #(
    parameter int W                     = 16,
    parameter int P_ADMIT_COMPLIMENT_EN = 1,
    parameter int CNT_W                 = 16
) (
    input  logic                 i_clk,
    input  logic                 i_arst,
    input  logic                 i_in_vld,
    input  logic [W-1:0]         i_in_x,
    output logic                 o_in_rdy,
    output logic                 o_out_vld,
    output logic [$clog2(W)-1:0] o_out_len,
    output logic                 o_out_compl,
    input  logic                 i_out_rdy,
    input  logic                 i_clr,
    output logic [CNT_W-1:0]     o_acc_cnt,
    output logic [CNT_W-1:0]     o_rej_cnt,
    output logic                 o_err
);

    localparam int LEN_W = $clog2(W);
    localparam logic [W-1:0] X_ONE = W'(1);

    // True when v is of the form 2^k-1 (including all-ones, which wraps to zero).
    function automatic logic is_mask(input logic [W-1:0] v);
        return ((v & (v + X_ONE)) == '0);
    endfunction

    function automatic logic [LEN_W-1:0] ones_cnt(input logic [W-1:0] v);
        logic [LEN_W:0] c;
        c = '0;
        for (int i = 0; i < W; i++) begin
            c = c + {{LEN_W{1'b0}}, v[i]};
        end
        return c[LEN_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Stage p0: combinational classification of the incoming vector
    logic [W-1:0]     x_inv_p0;
    logic             std_p0;
    logic             cpl_p0;
    logic             adm_p0;
    logic [LEN_W-1:0] len_p0;

    always_comb begin
        x_inv_p0 = ~i_in_x;
        std_p0   = is_mask(i_in_x) && !(&i_in_x);
        cpl_p0   = (P_ADMIT_COMPLIMENT_EN != 0) && is_mask(x_inv_p0) && (|i_in_x);
        adm_p0   = std_p0 || cpl_p0;
        len_p0   = cpl_p0 ? ones_cnt(x_inv_p0) : ones_cnt(i_in_x);
    end

    // Stage p1 is the skid entry, stage p2 the output register
    logic             vld_p1;
    logic [LEN_W-1:0] len_p1;
    logic             compl_p1;
    logic             vld_p2;
    logic [LEN_W-1:0] len_p2;
    logic             compl_p2;

    logic in_xfer;
    logic adm_xfer;
    logic rej_xfer;
    logic out_free;

    always_comb begin
        in_xfer  = i_in_vld && !vld_p1;
        adm_xfer = in_xfer && adm_p0;
        rej_xfer = in_xfer && !adm_p0;
        out_free = !vld_p2 || i_out_rdy;
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            vld_p1   <= 1'b0;
            len_p1   <= '0;
            compl_p1 <= 1'b0;
            vld_p2   <= 1'b0;
            len_p2   <= '0;
            compl_p2 <= 1'b0;
        end else if (out_free) begin
            // Skid entry always has priority so beats leave in arrival order.
            if (vld_p1) begin
                vld_p2   <= 1'b1;
                len_p2   <= len_p1;
                compl_p2 <= compl_p1;
                vld_p1   <= 1'b0;
            end else if (adm_xfer) begin
                vld_p2   <= 1'b1;
                len_p2   <= len_p0;
                compl_p2 <= cpl_p0;
            end else begin
                vld_p2   <= 1'b0;
            end
        end else if (adm_xfer) begin
            vld_p1   <= 1'b1;
            len_p1   <= len_p0;
            compl_p1 <= cpl_p0;
        end
    end

    // Status counters: clear takes priority over a same-cycle transfer
    logic [CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0] rej_cnt;
    logic             err;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            acc_cnt <= '0;
            rej_cnt <= '0;
            err     <= 1'b0;
        end else if (i_clr) begin
            acc_cnt <= '0;
            rej_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (adm_xfer) acc_cnt <= sat_inc(acc_cnt);
            if (rej_xfer) begin
                rej_cnt <= sat_inc(rej_cnt);
                err     <= 1'b1;
            end
        end
    end

    assign o_in_rdy    = !vld_p1;
    assign o_out_vld   = vld_p2;
    assign o_out_len   = len_p2;
    assign o_out_compl = compl_p2;
    assign o_acc_cnt   = acc_cnt;
    assign o_rej_cnt   = rej_cnt;
    assign o_err       = err;

endmodule

// File: tb/tb_e_stream_admit.sv
// Directed bench for e_stream_admit: three instances cover complement enabled,
// complement disabled, and narrow saturating counters.
module tb_e_stream_admit;

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance a: W=16, complement enabled, 16-bit counters
    logic        a_in_vld, a_in_rdy, a_out_vld, a_out_compl, a_out_rdy, a_clr, a_err;
    logic [15:0] a_in_x, a_acc, a_rej;
    logic [3:0]  a_out_len;
    // Instance b: complement disabled
    logic        b_in_vld, b_in_rdy, b_out_vld, b_out_compl, b_out_rdy, b_clr, b_err;
    logic [15:0] b_in_x, b_acc, b_rej;
    logic [3:0]  b_out_len;
    // Instance c: 2-bit counters
    logic        c_in_vld, c_in_rdy, c_out_vld, c_out_compl, c_out_rdy, c_clr, c_err;
    logic [15:0] c_in_x;
    logic [1:0]  c_acc, c_rej;
    logic [3:0]  c_out_len;

    e_stream_admit #(.W(16), .P_ADMIT_COMPLIMENT_EN(1), .CNT_W(16)) u_a (
        .i_clk(clk), .i_arst(arst), .i_in_vld(a_in_vld), .i_in_x(a_in_x), .o_in_rdy(a_in_rdy),
        .o_out_vld(a_out_vld), .o_out_len(a_out_len), .o_out_compl(a_out_compl),
        .i_out_rdy(a_out_rdy), .i_clr(a_clr), .o_acc_cnt(a_acc), .o_rej_cnt(a_rej), .o_err(a_err));

    e_stream_admit #(.W(16), .P_ADMIT_COMPLIMENT_EN(0), .CNT_W(16)) u_b (
        .i_clk(clk), .i_arst(arst), .i_in_vld(b_in_vld), .i_in_x(b_in_x), .o_in_rdy(b_in_rdy),
        .o_out_vld(b_out_vld), .o_out_len(b_out_len), .o_out_compl(b_out_compl),
        .i_out_rdy(b_out_rdy), .i_clr(b_clr), .o_acc_cnt(b_acc), .o_rej_cnt(b_rej), .o_err(b_err));

    e_stream_admit #(.W(16), .P_ADMIT_COMPLIMENT_EN(1), .CNT_W(2)) u_c (
        .i_clk(clk), .i_arst(arst), .i_in_vld(c_in_vld), .i_in_x(c_in_x), .o_in_rdy(c_in_rdy),
        .o_out_vld(c_out_vld), .o_out_len(c_out_len), .o_out_compl(c_out_compl),
        .i_out_rdy(c_out_rdy), .i_clr(c_clr), .o_acc_cnt(c_acc), .o_rej_cnt(c_rej), .o_err(c_err));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a_out(input string tag, input logic v, input logic [3:0] l, input logic c);
        chk({tag, "_vld"}, 32'(a_out_vld), 32'(v));
        chk({tag, "_len"}, 32'(a_out_len), 32'(l));
        chk({tag, "_compl"}, 32'(a_out_compl), 32'(c));
    endtask

    initial begin
        arst = 1'b1;
        a_in_vld = 0; a_in_x = '0; a_out_rdy = 1; a_clr = 0;
        b_in_vld = 0; b_in_x = '0; b_out_rdy = 1; b_clr = 0;
        c_in_vld = 0; c_in_x = '0; c_out_rdy = 1; c_clr = 0;
        #12;
        chk_a_out("rst_out", 1'b0, 4'd0, 1'b0);
        chk("rst_in_rdy", 32'(a_in_rdy), 32'd1);
        chk("rst_acc", 32'(a_acc), 32'd0);
        chk("rst_rej", 32'(a_rej), 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        arst = 1'b0;
        tick();
        chk("idle_vld", 32'(a_out_vld), 32'd0);

        // Complement disabled: top-bit-set vectors are rejected
        b_in_vld = 1; b_in_x = 16'hFFF0;
        tick();
        chk("b_fff0_vld", 32'(b_out_vld), 32'd0);
        chk("b_fff0_rej", 32'(b_rej), 32'd1);
        b_in_x = 16'hFFFF;
        tick();
        chk("b_ffff_vld", 32'(b_out_vld), 32'd0);
        chk("b_ffff_rej", 32'(b_rej), 32'd2);
        b_in_x = 16'h7FFF;
        tick();
        chk("b_7fff_vld", 32'(b_out_vld), 32'd1);
        chk("b_7fff_len", 32'(b_out_len), 32'd15);
        chk("b_7fff_compl", 32'(b_out_compl), 32'd0);
        chk("b_acc", 32'(b_acc), 32'd1);
        chk("b_rej", 32'(b_rej), 32'd2);
        chk("b_err", 32'(b_err), 32'd1);
        b_in_vld = 0;

        // Narrow counters saturate; clear beats a same-cycle reject
        c_in_vld = 1; c_in_x = 16'h0005;
        tick(); tick(); tick();
        chk("c_rej3", 32'(c_rej), 32'd3);
        tick(); tick();
        chk("c_rej_sat", 32'(c_rej), 32'd3);
        chk("c_err_set", 32'(c_err), 32'd1);
        chk("c_no_out", 32'(c_out_vld), 32'd0);
        c_clr = 1;
        tick();
        chk("c_clr_rej", 32'(c_rej), 32'd0);
        chk("c_clr_err", 32'(c_err), 32'd0);
        c_clr = 0; c_in_vld = 0;
        tick();
        chk("c_idle_rej", 32'(c_rej), 32'd0);
        chk("c_idle_err", 32'(c_err), 32'd0);

        // Back-to-back stream with both forms and the all-zero/all-one edge cases
        a_in_vld = 1; a_in_x = 16'h0007;
        tick();
        chk_a_out("s0", 1'b1, 4'd3, 1'b0);
        a_in_x = 16'hFFF8;
        tick();
        chk_a_out("s1", 1'b1, 4'd3, 1'b1);
        a_in_x = 16'h0000;
        tick();
        chk_a_out("s2", 1'b1, 4'd0, 1'b0);
        a_in_x = 16'hFFFF;
        tick();
        chk_a_out("s3", 1'b1, 4'd0, 1'b1);
        a_in_vld = 0;
        tick();
        chk("s_end_vld", 32'(a_out_vld), 32'd0);
        chk("s_acc", 32'(a_acc), 32'd4);
        chk("s_err", 32'(a_err), 32'd0);

        a_clr = 1;
        tick();
        a_clr = 0;
        chk("clr_acc", 32'(a_acc), 32'd0);

        // Rejected beat is dropped, the following admitted one goes out
        a_in_vld = 1; a_in_x = 16'h0005;
        tick();
        chk("rej_vld", 32'(a_out_vld), 32'd0);
        chk("rej_cnt", 32'(a_rej), 32'd1);
        chk("rej_err", 32'(a_err), 32'd1);
        a_in_x = 16'h0001;
        tick();
        chk_a_out("after_rej", 1'b1, 4'd1, 1'b0);
        chk("after_rej_acc", 32'(a_acc), 32'd1);
        chk("after_rej_rej", 32'(a_rej), 32'd1);
        a_in_vld = 0;
        tick();
        chk("after_rej_idle", 32'(a_out_vld), 32'd0);

        // Backpressure: output plus skid fill, then drain in order
        a_out_rdy = 0; a_in_vld = 1; a_in_x = 16'h0001;
        tick();
        chk_a_out("bp0", 1'b1, 4'd1, 1'b0);
        chk("bp0_rdy", 32'(a_in_rdy), 32'd1);
        a_in_x = 16'h0003;
        tick();
        chk_a_out("bp1", 1'b1, 4'd1, 1'b0);
        chk("bp1_rdy", 32'(a_in_rdy), 32'd0);
        a_in_x = 16'h0007;
        tick();
        chk_a_out("bp2_hold", 1'b1, 4'd1, 1'b0);
        chk("bp2_rdy", 32'(a_in_rdy), 32'd0);
        chk("bp2_acc", 32'(a_acc), 32'd3);
        a_out_rdy = 1;
        tick();
        chk_a_out("dr1", 1'b1, 4'd2, 1'b0);
        chk("dr1_rdy", 32'(a_in_rdy), 32'd1);
        tick();
        chk_a_out("dr2", 1'b1, 4'd3, 1'b0);
        chk("dr2_acc", 32'(a_acc), 32'd4);
        a_in_vld = 0;
        tick();
        chk("dr_end_vld", 32'(a_out_vld), 32'd0);
        chk("dr_end_acc", 32'(a_acc), 32'd4);

        // Asynchronous reset with both entries full
        a_out_rdy = 0; a_in_vld = 1; a_in_x = 16'h000F;
        tick();
        a_in_x = 16'h001F;
        tick();
        chk("full_rdy", 32'(a_in_rdy), 32'd0);
        a_in_vld = 0;
        #2 arst = 1'b1;
        #1;
        chk("ar_vld", 32'(a_out_vld), 32'd0);
        chk("ar_rdy", 32'(a_in_rdy), 32'd1);
        chk("ar_len", 32'(a_out_len), 32'd0);
        chk("ar_acc", 32'(a_acc), 32'd0);
        chk("ar_err", 32'(a_err), 32'd0);
        chk("ar_b_rej", 32'(b_rej), 32'd0);
        #10 arst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
